// File: rtl/fft_bfly_stage.sv
// Pipelined radix-2 DIT butterfly: X = A + W*B, Y = A - W*B on packed {re, im} words.
// Stage 1 registers the twiddle product, stage 2 registers the sum/difference; valid/ready flow control.
module fft_bfly_stage #(
    parameter int W     = 32,
    parameter int P     = 16,
    parameter int SCALE = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] in_a,
    input  logic [2*W-1:0] in_b,
    input  logic [2*W-1:0] in_tw,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_x,
    output logic [2*W-1:0] out_y,
    output logic           out_last
);

    localparam int PW = P + W;

    // Products are formed modulo 2^(P+W) on sign-extended operands; the low P+W bits
    // of a two's-complement product are exact, and bits [P+W-1:P] are the Q-format result.
    function automatic logic [2*W-1:0] cmplx_mul(input logic [2*W-1:0] a,
                                                 input logic [2*W-1:0] b);
        logic [PW-1:0] ar, ai, br, bi, re, im;
        ar = {{P{a[2*W-1]}}, a[2*W-1:W]};
        ai = {{P{a[W-1]}}, a[W-1:0]};
        br = {{P{b[2*W-1]}}, b[2*W-1:W]};
        bi = {{P{b[W-1]}}, b[W-1:0]};
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return {W'(re >> P), W'(im >> P)};
    endfunction

    function automatic logic [2*W-1:0] cmplx_add(input logic [2*W-1:0] a,
                                                 input logic [2*W-1:0] b);
        return {a[2*W-1:W] + b[2*W-1:W], a[W-1:0] + b[W-1:0]};
    endfunction

    function automatic logic [2*W-1:0] cmplx_sub(input logic [2*W-1:0] a,
                                                 input logic [2*W-1:0] b);
        return {a[2*W-1:W] - b[2*W-1:W], a[W-1:0] - b[W-1:0]};
    endfunction

    function automatic logic [2*W-1:0] cmplx_half(input logic [2*W-1:0] a);
        return {a[2*W-1], a[2*W-1:W+1], a[W-1], a[W-1:1]};
    endfunction

    logic           s1_valid;
    logic           s2_valid;
    logic           s1_free;
    logic           s2_free;
    logic [2*W-1:0] p1;
    logic [2*W-1:0] a1;
    logic           last1;
    logic [2*W-1:0] sum_c;
    logic [2*W-1:0] dif_c;
    logic [2*W-1:0] x_next;
    logic [2*W-1:0] y_next;

    // in_ready depends on out_ready and the valid bits only, never on in_valid.
    assign s2_free   = !s2_valid || out_ready;
    assign s1_free   = !s1_valid || s2_free;
    assign in_ready  = s1_free;
    assign out_valid = s2_valid;

    always_comb begin
        sum_c  = cmplx_add(a1, p1);
        dif_c  = cmplx_sub(a1, p1);
        x_next = sum_c;
        y_next = dif_c;
        if (SCALE != 0) begin
            x_next = cmplx_half(sum_c);
            y_next = cmplx_half(dif_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            p1       <= '0;
            a1       <= '0;
            last1    <= 1'b0;
        end else if (s1_free) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                p1    <= cmplx_mul(in_tw, in_b);
                a1    <= in_a;
                last1 <= in_last;
            end
        end
    end

    // A bubble only clears s2_valid; the output data registers keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_x    <= '0;
            out_y    <= '0;
            out_last <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_x    <= x_next;
                out_y    <= y_next;
                out_last <= last1;
            end
        end
    end

endmodule

// File: tb/tb_fft_bfly_stage.sv
// Directed bench for fft_bfly_stage: one unscaled and one scaled instance share all inputs.
module tb_fft_bfly_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [63:0] in_tw;
    logic        in_last;
    logic        out_ready;

    logic        ir0, ov0, last0;
    logic [63:0] x0, y0;
    logic        ir1, ov1, last1;
    logic [63:0] x1, y1;

    int total = 0;
    int bad   = 0;

    logic [128:0] exp_q[$];

    fft_bfly_stage #(.W(32), .P(16), .SCALE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .in_a(in_a), .in_b(in_b), .in_tw(in_tw), .in_last(in_last),
        .out_valid(ov0), .out_ready(out_ready), .out_x(x0), .out_y(y0), .out_last(last0)
    );

    fft_bfly_stage #(.W(32), .P(16), .SCALE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .in_a(in_a), .in_b(in_b), .in_tw(in_tw), .in_last(in_last),
        .out_valid(ov1), .out_ready(out_ready), .out_x(x1), .out_y(y1), .out_last(last1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated butterfly with out_ready=1; checks latency and both instances' results.
    task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] tw, input logic [63:0] ex0, input logic [63:0] ey0,
                           input logic [63:0] ex1, input logic [63:0] ey1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_tw     = tw;
        in_last   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_tw    = '0;
        in_last  = 1'b0;
        check({tag, "_lat1_valid"}, 128'(ov0), 128'(1'b0));
        @(posedge clk); #1;
        check({tag, "_valid"}, 128'(ov0), 128'(1'b1));
        check({tag, "_x"}, 128'(x0), 128'(ex0));
        check({tag, "_y"}, 128'(y0), 128'(ey0));
        check({tag, "_last"}, 128'(last0), 128'(1'b1));
        check({tag, "_valid_s"}, 128'(ov1), 128'(1'b1));
        check({tag, "_x_s"}, 128'(x1), 128'(ex1));
        check({tag, "_y_s"}, 128'(y1), 128'(ey1));
        @(posedge clk); #1;
        check({tag, "_drained"}, 128'(ov0), 128'(1'b0));
    endtask

    // Streams n butterflies with twiddle 1.0, so the expected results are simply A+B and A-B.
    // out_ready is held low for the first 'stall' cycles.
    task automatic run_stream(input string tag, input int n, input int stall);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        logic [31:0] ar, ai;
        logic [128:0] e;
        logic [31:0] br = 32'h0003_0000;
        logic [31:0] bi = 32'h0000_0001;
        exp_q.delete();
        while (got < n && cyc < 200) begin
            @(posedge clk); #1;
            out_ready = (cyc >= stall);
            in_valid  = (sent < n);
            ar        = 32'(sent) << 16;
            ai        = 32'(sent) * 32'h1000;
            in_a      = {ar, ai};
            in_b      = {br, bi};
            in_tw     = {32'h0001_0000, 32'h0};
            in_last   = (sent == n - 1);
            @(negedge clk);
            if (stall == 0 && sent < n)
                check({tag, "_in_ready"}, 128'(ir0), 128'(1'b1));
            if (stall == 0 && got > 0 && got < n)
                check({tag, "_contiguous"}, 128'(ov0), 128'(1'b1));
            if (stall > 0 && cyc == stall - 1) begin
                check({tag, "_accepts_in_stall"}, 128'(sent), 128'(2));
                check({tag, "_in_ready_low"}, 128'(ir0), 128'(1'b0));
                check({tag, "_held_valid"}, 128'(ov0), 128'(1'b1));
                check({tag, "_held_x"}, 128'(x0), 128'(exp_q[0][127:64]));
            end
            if (in_valid && ir0) begin
                exp_q.push_back({in_last, ar + br, ai + bi, ar - br, ai - bi});
                sent++;
            end
            if (ov0 && out_ready) begin
                check({tag, "_sb_nonempty"}, 128'(exp_q.size() > 0), 128'(1'b1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_x"}, 128'(x0), 128'(e[127:64]));
                    check({tag, "_y"}, 128'(y0), 128'(e[63:0]));
                    check({tag, "_last"}, 128'(last0), 128'(e[128]));
                end
                got++;
            end
            cyc++;
        end
        check({tag, "_count_in_budget"}, 128'(got), 128'(n));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk); #1;
        check({tag, "_no_extra"}, 128'(ov0), 128'(1'b0));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tw     = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(ov0), 128'(1'b0));
        check("rst_in_ready", 128'(ir0), 128'(1'b1));
        check("rst_out_x", 128'(x0), 128'(0));
        check("rst_out_y", 128'(y0), 128'(0));
        check("rst_out_last", 128'(last0), 128'(1'b0));
        rst_n = 1'b1;

        // 1.0 + 0.5*2.0 = 2.0 ; scaled halves it
        run_one("basic", {32'h0001_0000, 32'h0}, {32'h0002_0000, 32'h0}, {32'h0000_8000, 32'h0},
                {32'h0002_0000, 32'h0}, 64'h0, {32'h0001_0000, 32'h0}, 64'h0);
        // j * 1.0 = j
        run_one("ctw", 64'h0, {32'h0001_0000, 32'h0}, {32'h0, 32'h0001_0000},
                {32'h0, 32'h0001_0000}, {32'h0, 32'hFFFF_0000},
                {32'h0, 32'h0000_8000}, {32'h0, 32'hFFFF_8000});
        // (0.5+0.5j)*(2+2j) = 0+2j
        run_one("ctw2", 64'h0, {32'h0002_0000, 32'h0002_0000}, {32'h0000_8000, 32'h0000_8000},
                {32'h0, 32'h0002_0000}, {32'h0, 32'hFFFE_0000},
                {32'h0, 32'h0001_0000}, {32'h0, 32'hFFFF_0000});
        // -1 * (1+3j) = -1-3j
        run_one("neg", 64'h0, {32'h0001_0000, 32'h0003_0000}, {32'hFFFF_0000, 32'h0},
                {32'hFFFF_0000, 32'hFFFD_0000}, {32'h0001_0000, 32'h0003_0000},
                {32'hFFFF_8000, 32'hFFFE_8000}, {32'h0000_8000, 32'h0001_8000});
        // -2.0 + 0 : scaling must replicate the sign bit
        run_one("scale_neg", {32'hFFFE_0000, 32'h0}, 64'h0, {32'h0001_0000, 32'h0},
                {32'hFFFE_0000, 32'h0}, {32'hFFFE_0000, 32'h0},
                {32'hFFFF_0000, 32'h0}, {32'hFFFF_0000, 32'h0});

        run_stream("stream", 8, 0);
        run_stream("bp", 8, 5);

        // Fill both stages under backpressure, then reset asynchronously mid-cycle.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = {32'h0001_0000, 32'h0};
        in_b      = {32'h0001_0000, 32'h0};
        in_tw     = {32'h0001_0000, 32'h0};
        in_last   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("pre_rst_out_valid", 128'(ov0), 128'(1'b1));
        check("pre_rst_in_ready", 128'(ir0), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 128'(ov0), 128'(1'b0));
        check("async_rst_out_x", 128'(x0), 128'(0));
        check("async_rst_out_last", 128'(last0), 128'(1'b0));
        check("async_rst_valid_s", 128'(ov1), 128'(1'b0));
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check("post_rst_in_ready", 128'(ir0), 128'(1'b1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_stale", 128'(ov0), 128'(1'b0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
